// File: rtl/reorder_buffer_if.sv
// Rename <-> reorder buffer link: micro-op allocation, execute completions,
// branch resolution, retirement to the free list and recovery pulses back to rename.
package reorder_buffer_pkg;
    localparam int PC_W   = 32;
    localparam int PREG_W = 7;
    localparam int TAG_W  = 4;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [PREG_W-1:0] pd_new;
        logic [PREG_W-1:0] pd_old;
        logic [TAG_W-1:0]  rob_tag;
    } rename_data;
endpackage

interface reorder_buffer_if;
    logic                                     valid_in;
    reorder_buffer_pkg::rename_data           data_in;
    logic                                     ready_in;
    logic                                     cmpl_valid;
    logic [reorder_buffer_pkg::TAG_W-1:0]     cmpl_tag;
    logic                                     br_valid;
    logic [reorder_buffer_pkg::TAG_W-1:0]     br_tag;
    logic                                     br_mispredict;
    logic                                     write_en;
    logic [reorder_buffer_pkg::PREG_W-1:0]    rob_data_in;
    logic                                     mispredict;
    logic                                     hit;
    logic [reorder_buffer_pkg::TAG_W:0]       mispredict_tag;
    logic                                     tag_err;

    modport master (
        output valid_in, data_in, cmpl_valid, cmpl_tag, br_valid, br_tag, br_mispredict,
        input  ready_in, write_en, rob_data_in, mispredict, hit, mispredict_tag, tag_err
    );

    modport slave (
        input  valid_in, data_in, cmpl_valid, cmpl_tag, br_valid, br_tag, br_mispredict,
        output ready_in, write_en, rob_data_in, mispredict, hit, mispredict_tag, tag_err
    );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates renamed micro-ops at tail, marks completions,
// resolves branches into mispredict/hit pulses and retires one entry per cycle from head.
module reorder_buffer #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    reorder_buffer_if.slave rob
);
    import reorder_buffer_pkg::PC_W;
    import reorder_buffer_pkg::PREG_W;

    localparam logic [TAG_W:0]   FULL    = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W:0]   CNT_ONE = (TAG_W+1)'(1);
    localparam logic [TAG_W-1:0] TAG_ONE = TAG_W'(1);

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  done_q;
    logic [PREG_W-1:0] pd_new_q [DEPTH];
    logic [PREG_W-1:0] pd_old_q [DEPTH];
    logic [PC_W-1:0]   pc_q     [DEPTH];
    logic [TAG_W-1:0]  head;
    logic [TAG_W-1:0]  tail;
    logic [TAG_W:0]    count;

    logic [TAG_W-1:0]  cmpl_age;
    logic [TAG_W-1:0]  br_age;
    logic              cmpl_live;
    logic              br_live;
    logic              do_alloc;
    logic              do_retire;
    logic              do_flush;
    logic              do_hit;
    logic [DEPTH-1:0]  younger;
    logic [TAG_W:0]    count_next;

    // pc is held per entry for debug visibility; nothing downstream consumes it yet
    logic unused_pc;
    assign unused_pc = ^pc_q[head];

    assign rob.ready_in = (count != FULL) && !rob.mispredict;

    // A tag is live when its distance from head is inside the occupied window.
    // A flush drops any allocation in the same cycle, so tail is restored cleanly.
    always_comb begin
        cmpl_age   = rob.cmpl_tag - head;
        br_age     = rob.br_tag - head;
        cmpl_live  = rob.cmpl_valid && ({1'b0, cmpl_age} < count);
        br_live    = rob.br_valid && ({1'b0, br_age} < count);
        do_retire  = valid_q[head] && done_q[head];
        do_flush   = br_live && rob.br_mispredict;
        do_hit     = br_live && !rob.br_mispredict;
        do_alloc   = rob.valid_in && rob.ready_in && !do_flush;
        younger    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            younger[i] = (TAG_W'(i) - head) > br_age;
        end
        if (do_flush) begin
            count_next = {1'b0, br_age} + CNT_ONE - {{TAG_W{1'b0}}, do_retire};
        end else begin
            count_next = count + {{TAG_W{1'b0}}, do_alloc} - {{TAG_W{1'b0}}, do_retire};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head               <= '0;
            tail               <= '0;
            count              <= '0;
            valid_q            <= '0;
            done_q             <= '0;
            rob.write_en       <= 1'b0;
            rob.rob_data_in    <= '0;
            rob.mispredict     <= 1'b0;
            rob.hit            <= 1'b0;
            rob.mispredict_tag <= '0;
            rob.tag_err        <= 1'b0;
        end else begin
            rob.write_en       <= do_retire;
            rob.rob_data_in    <= (do_retire && pd_new_q[head] != '0) ? pd_old_q[head] : '0;
            rob.mispredict     <= do_flush;
            rob.hit            <= do_hit;
            rob.mispredict_tag <= br_live ? {1'b0, rob.br_tag} : '0;
            count              <= count_next;

            if (do_alloc) begin
                valid_q[tail]  <= 1'b1;
                done_q[tail]   <= 1'b0;
                pd_new_q[tail] <= rob.data_in.pd_new;
                pd_old_q[tail] <= rob.data_in.pd_old;
                pc_q[tail]     <= rob.data_in.pc;
                tail           <= tail + TAG_ONE;
                if (rob.data_in.rob_tag != tail) begin
                    rob.tag_err <= 1'b1;
                end
            end

            if (cmpl_live) begin
                done_q[rob.cmpl_tag] <= 1'b1;
            end
            if (br_live) begin
                done_q[rob.br_tag] <= 1'b1;
            end

            if (do_retire) begin
                valid_q[head] <= 1'b0;
                head          <= head + TAG_ONE;
            end

            // The branch survives a flush; only entries younger than it are squashed
            if (do_flush) begin
                tail <= rob.br_tag + TAG_ONE;
                for (int i = 0; i < DEPTH; i++) begin
                    if (younger[i]) begin
                        valid_q[i] <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a table of allocate/complete/retire vectors
// followed by directed sequences for full, wrap, flush, hit and tag-error cases.
module tb_reorder_buffer;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    reorder_buffer_if rif();

    reorder_buffer #(.DEPTH(16), .TAG_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .rob   (rif)
    );

    typedef struct {
        logic       valid;
        logic [3:0] tag;
        logic [6:0] pd_new;
        logic [6:0] pd_old;
        logic       cv;
        logic [3:0] ct;
        logic       exp_ready;
        logic       exp_we;
        logic [6:0] exp_data;
        logic [4:0] exp_count;
    } vec_t;

    vec_t vecs[10];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [3:0] tag, input logic [6:0] pd_new,
                                 input logic [6:0] pd_old, input logic cv, input logic [3:0] ct,
                                 input logic bv, input logic [3:0] bt, input logic bm);
        rif.valid_in        = valid;
        rif.data_in.pc      = 32'h1000 + {26'd0, tag, 2'b00};
        rif.data_in.pd_new  = pd_new;
        rif.data_in.pd_old  = pd_old;
        rif.data_in.rob_tag = tag;
        rif.cmpl_valid      = cv;
        rif.cmpl_tag        = ct;
        rif.br_valid        = bv;
        rif.br_tag          = bt;
        rif.br_mispredict   = bm;
    endtask

    task automatic clearInputs();
        applyStimulus(1'b0, 4'd0, 7'd0, 7'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        clearInputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic allocSix();
        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 4'(i), 7'(40 + i), 7'(20 + i), 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
            step();
        end
        clearInputs();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 4'd0, 7'd33, 7'd5, 1'b0, 4'd0, 1'b1, 1'b0, 7'd0, 5'd1};
        vecs[1] = '{1'b1, 4'd1, 7'd0,  7'd9, 1'b0, 4'd0, 1'b1, 1'b0, 7'd0, 5'd2};
        vecs[2] = '{1'b1, 4'd2, 7'd35, 7'd7, 1'b0, 4'd0, 1'b1, 1'b0, 7'd0, 5'd3};
        vecs[3] = '{1'b0, 4'd0, 7'd0,  7'd0, 1'b1, 4'd2, 1'b1, 1'b0, 7'd0, 5'd3};
        vecs[4] = '{1'b0, 4'd0, 7'd0,  7'd0, 1'b1, 4'd0, 1'b1, 1'b0, 7'd0, 5'd3};
        vecs[5] = '{1'b0, 4'd0, 7'd0,  7'd0, 1'b0, 4'd0, 1'b1, 1'b1, 7'd5, 5'd2};
        vecs[6] = '{1'b0, 4'd0, 7'd0,  7'd0, 1'b1, 4'd1, 1'b1, 1'b0, 7'd0, 5'd2};
        vecs[7] = '{1'b0, 4'd0, 7'd0,  7'd0, 1'b0, 4'd0, 1'b1, 1'b1, 7'd0, 5'd1};
        vecs[8] = '{1'b0, 4'd0, 7'd0,  7'd0, 1'b0, 4'd0, 1'b1, 1'b1, 7'd7, 5'd0};
        vecs[9] = '{1'b0, 4'd0, 7'd0,  7'd0, 1'b0, 4'd0, 1'b1, 1'b0, 7'd0, 5'd0};

        // Reset values
        clearInputs();
        reset = 1'b1;
        step();
        checkOutput("rst.ready_in", rif.ready_in, 1);
        checkOutput("rst.write_en", rif.write_en, 0);
        checkOutput("rst.rob_data_in", rif.rob_data_in, 0);
        checkOutput("rst.mispredict", rif.mispredict, 0);
        checkOutput("rst.hit", rif.hit, 0);
        checkOutput("rst.mispredict_tag", rif.mispredict_tag, 0);
        checkOutput("rst.tag_err", rif.tag_err, 0);
        checkOutput("rst.count", dut.count, 0);
        reset = 1'b0;

        // Out-of-order completion, in-order retirement
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].tag, vecs[i].pd_new, vecs[i].pd_old,
                          vecs[i].cv, vecs[i].ct, 1'b0, 4'd0, 1'b0);
            step();
            checkOutput($sformatf("vec%0d.ready_in", i), rif.ready_in, 32'(vecs[i].exp_ready));
            checkOutput($sformatf("vec%0d.write_en", i), rif.write_en, 32'(vecs[i].exp_we));
            checkOutput($sformatf("vec%0d.rob_data_in", i), rif.rob_data_in, 32'(vecs[i].exp_data));
            checkOutput($sformatf("vec%0d.count", i), dut.count, 32'(vecs[i].exp_count));
        end

        // Fill to 16, overflow attempt, retire one and wrap allocation to tag 0
        doReset();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 4'(i), 7'(40 + i), 7'(20 + i), 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
            step();
        end
        checkOutput("full.ready_in", rif.ready_in, 0);
        checkOutput("full.count", dut.count, 16);
        applyStimulus(1'b1, 4'd5, 7'd1, 7'd1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        step();
        checkOutput("full.ovf_count", dut.count, 16);
        checkOutput("full.ovf_tail", dut.tail, 0);
        checkOutput("full.ovf_tag_err", rif.tag_err, 0);
        applyStimulus(1'b0, 4'd0, 7'd0, 7'd0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        step();
        clearInputs();
        step();
        checkOutput("full.retire_we", rif.write_en, 1);
        checkOutput("full.retire_data", rif.rob_data_in, 20);
        checkOutput("full.retire_count", dut.count, 15);
        checkOutput("full.retire_ready", rif.ready_in, 1);
        applyStimulus(1'b1, 4'd0, 7'd60, 7'd61, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        step();
        checkOutput("wrap.tail", dut.tail, 1);
        checkOutput("wrap.count", dut.count, 16);
        checkOutput("wrap.tag_err", rif.tag_err, 0);
        checkOutput("wrap.pd_old", dut.pd_old_q[0], 61);

        // Mispredict on tag 2 squashes 3..5
        allocSix();
        applyStimulus(1'b0, 4'd0, 7'd0, 7'd0, 1'b0, 4'd0, 1'b1, 4'd2, 1'b1);
        step();
        checkOutput("mp.mispredict", rif.mispredict, 1);
        checkOutput("mp.hit", rif.hit, 0);
        checkOutput("mp.tag", rif.mispredict_tag, 2);
        checkOutput("mp.ready_in", rif.ready_in, 0);
        checkOutput("mp.count", dut.count, 3);
        checkOutput("mp.tail", dut.tail, 3);
        checkOutput("mp.valid", dut.valid_q, 32'h0007);
        applyStimulus(1'b1, 4'd3, 7'd50, 7'd30, 1'b1, 4'd4, 1'b0, 4'd0, 1'b0);
        step();
        checkOutput("mp.pulse_end", rif.mispredict, 0);
        checkOutput("mp.dropped_tail", dut.tail, 3);
        checkOutput("mp.stale_cmpl4", dut.done_q[4], 0);
        checkOutput("mp.count_hold", dut.count, 3);
        applyStimulus(1'b1, 4'd3, 7'd50, 7'd30, 1'b1, 4'd5, 1'b0, 4'd0, 1'b0);
        step();
        checkOutput("mp.resume_tail", dut.tail, 4);
        checkOutput("mp.resume_count", dut.count, 4);
        checkOutput("mp.stale_cmpl5", dut.done_q[5], 0);
        checkOutput("mp.tag_err", rif.tag_err, 0);

        // Correct prediction on tag 2 keeps everything
        allocSix();
        applyStimulus(1'b0, 4'd0, 7'd0, 7'd0, 1'b0, 4'd0, 1'b1, 4'd2, 1'b0);
        step();
        checkOutput("hit.hit", rif.hit, 1);
        checkOutput("hit.mispredict", rif.mispredict, 0);
        checkOutput("hit.tag", rif.mispredict_tag, 2);
        checkOutput("hit.count", dut.count, 6);
        clearInputs();
        step();
        checkOutput("hit.pulse_end", rif.hit, 0);
        checkOutput("hit.valid", dut.valid_q, 32'h003F);
        checkOutput("hit.tail", dut.tail, 6);

        // Flush on tag 15 while tag 14 retires, across the wrap
        doReset();
        for (int i = 0; i < 18; i++) begin
            applyStimulus(1'b1, 4'(i % 16), 7'(40 + (i % 16)), 7'(20 + (i % 16)),
                          (i > 0 && i <= 14), 4'(i - 1), 1'b0, 4'd0, 1'b0);
            step();
        end
        checkOutput("wrapmp.head", dut.head, 14);
        checkOutput("wrapmp.count", dut.count, 4);
        applyStimulus(1'b0, 4'd0, 7'd0, 7'd0, 1'b1, 4'd14, 1'b0, 4'd0, 1'b0);
        step();
        applyStimulus(1'b0, 4'd0, 7'd0, 7'd0, 1'b0, 4'd0, 1'b1, 4'd15, 1'b1);
        step();
        checkOutput("wrapmp.mispredict", rif.mispredict, 1);
        checkOutput("wrapmp.tag", rif.mispredict_tag, 15);
        checkOutput("wrapmp.write_en", rif.write_en, 1);
        checkOutput("wrapmp.data", rif.rob_data_in, 34);
        checkOutput("wrapmp.count_after", dut.count, 1);
        checkOutput("wrapmp.head_after", dut.head, 15);
        checkOutput("wrapmp.tail_after", dut.tail, 0);
        clearInputs();

        // Tag mismatch is sticky and the entry still lands at tail
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'(i), 7'(40 + i), 7'(20 + i), 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
            step();
        end
        checkOutput("tagerr.before", rif.tag_err, 0);
        applyStimulus(1'b1, 4'd7, 7'd44, 7'd24, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        step();
        checkOutput("tagerr.flag", rif.tag_err, 1);
        checkOutput("tagerr.tail", dut.tail, 4);
        checkOutput("tagerr.valid3", dut.valid_q[3], 1);
        checkOutput("tagerr.pd_old3", dut.pd_old_q[3], 24);
        clearInputs();
        step();
        step();
        checkOutput("tagerr.sticky", rif.tag_err, 1);

        // Reset mid-operation discards a ready-to-retire entry
        applyStimulus(1'b0, 4'd0, 7'd0, 7'd0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        step();
        clearInputs();
        reset = 1'b1;
        step();
        checkOutput("midrst.write_en", rif.write_en, 0);
        checkOutput("midrst.count", dut.count, 0);
        checkOutput("midrst.tag_err", rif.tag_err, 0);
        checkOutput("midrst.valid", dut.valid_q, 0);
        reset = 1'b0;
        step();
        checkOutput("midrst.no_retire", rif.write_en, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
